// File: rtl/irq_arbiter.sv
// Avalon-MM interrupt arbiter: edge-captured pending bits, mask, and a single granted vector.
// Define IRQ_ARBITER_RR_EN for round-robin arbitration; the default build is fixed priority.
module irq_arbiter #(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [N_SRC-1:0] irq_src,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [4:0] NSrc = 5'(N_SRC);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] meta_q, sync1_q, sync2_q;
  logic [1:0]       arm_q, arm_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [3:0]       grant_id_q, grant_id_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en, wr_pend, wr_mask, wr_ack;
  logic [N_SRC-1:0] wdata, edge_det, gid_oh, req, ack_clr, w1c_clr;
  logic             ack_fire, release_grant;
  logic             win_vld;
  logic [3:0]       win_id;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wr_pend      = wr_en && (address == 2'd0);
  assign wr_mask      = wr_en && (address == 2'd1);
  assign wr_ack       = wr_en && (address == 2'd3);
  assign wdata        = writedata[N_SRC-1:0];
  assign unused_wdata = ^writedata[31:N_SRC];

  // Edges are suppressed until the synchronizer has been refilled from the live inputs,
  // so a source already high at reset release does not look like a fresh rise.
  assign edge_det = (arm_q == 2'd3) ? (sync1_q & ~sync2_q) : '0;
  assign req      = pending_q & mask_q;
  assign gid_oh   = N_SRC'(1) << grant_id_q;
  assign ack_fire = wr_ack && (state_q == StGrant);
  assign ack_clr  = ack_fire ? gid_oh : '0;
  assign w1c_clr  = wr_pend ? wdata : '0;

  assign release_grant = (wr_pend && (|(wdata & gid_oh))) ||
                         (wr_mask && !(|(wdata & gid_oh)));

`ifdef IRQ_ARBITER_RR_EN
  logic [3:0]       ptr_q, ptr_d;
  logic [N_SRC-1:0] req_rot;
  logic [3:0]       rot_off;
  logic [4:0]       win_sum, ptr_sum;

  // Rotate requests so the search starts at the pointer, then undo the rotation.
  always_comb begin
    req_rot = N_SRC'({req, req} >> ptr_q);
    win_vld = |req_rot;
    rot_off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_off = 4'(i);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, rot_off};
    if (win_sum >= NSrc) win_sum = win_sum - NSrc;
    win_id = win_sum[3:0];
  end

  always_comb begin
    ptr_d   = ptr_q;
    ptr_sum = {1'b0, win_id} + 5'd1;
    if (state_q == StIdle && win_vld) begin
      ptr_d = (ptr_sum == NSrc) ? 4'd0 : ptr_sum[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_id = 4'(i);
    end
  end

  assign win_vld = |req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_vld) state_d = StGrant;
      StGrant: begin
        if (ack_fire)           state_d = StHold;
        else if (release_grant) state_d = StIdle;
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    irq = (state_q == StGrant);
  end

  always_comb begin
    // A new edge wins over a same-cycle clear of the same bit.
    pending_d  = (pending_q & ~(ack_clr | w1c_clr)) | edge_det;
    mask_d     = wr_mask ? wdata : mask_q;
    grant_id_d = (state_q == StIdle && win_vld) ? win_id : grant_id_q;
    arm_d      = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d = 32'(pending_q);
      2'd1:    readdata_d = 32'(mask_q);
      2'd2:    readdata_d = {irq, 27'd0, grant_id_q};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      arm_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      grant_id_q <= '0;
      readdata_q <= '0;
    end else begin
      meta_q     <= irq_src;
      sync1_q    <= meta_q;
      sync2_q    <= sync1_q;
      arm_q      <= arm_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      grant_id_q <= grant_id_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, meaning the number of interrupt sources; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port address, input, 2 bits, the Avalon-MM word address.
REQ-005 The block SHALL have port chipselect, input, 1 bit, the slave select.
REQ-006 The block SHALL have port write_n, input, 1 bit, an active-low write strobe.
REQ-007 The block SHALL have port writedata, input, 32 bits, the write data.
REQ-008 The block SHALL have port irq_src, input, N_SRC bits, asynchronous level interrupt sources (G-sensor int, key PIOs, ...).
REQ-009 The block SHALL have port readdata, output, 32 bits, registered read data.
REQ-010 The block SHALL have port irq, output, 1 bit, the interrupt request to the CPU.

Function
REQ-011 Each irq_src bit SHALL pass a 2-flop synchronizer; a rising edge SHALL be detected as sync1 & ~sync2, giving 3 clk cycles from an input rise to the pending bit set.
REQ-012 A detected edge SHALL set the corresponding PENDING bit, which stays set until cleared.
REQ-013 Register map: 0 = PENDING (read; write-1-to-clear); 1 = MASK (read/write, bits N_SRC-1:0); 2 = VECTOR (read only: bit31 = valid, bits 3:0 = grant_id); 3 = ACK (write only, data ignored).
REQ-014 A write SHALL be recognised when chipselect=1 and write_n=0.
REQ-015 readdata SHALL update every cycle from the address-selected mux, with 1 cycle of latency; unused bits SHALL read 0 and ACK SHALL read 0.
REQ-016 The FSM SHALL have states IDLE, GRANT and HOLD.
REQ-017 IDLE: if (PENDING & MASK) is nonzero, the winner SHALL be latched into grant_id and the FSM SHALL go to GRANT on the next cycle; otherwise it stays in IDLE.
REQ-018 irq SHALL be 1 exactly when state is GRANT; VECTOR.valid SHALL equal irq.
REQ-019 GRANT: an ACK write SHALL clear PENDING[grant_id] and move to HOLD.
REQ-020 GRANT: a W1C write that clears PENDING[grant_id], or a MASK write that clears MASK[grant_id], SHALL move to IDLE without a separate ACK.
REQ-021 HOLD SHALL last exactly 1 cycle with irq=0 and then go to IDLE, guaranteeing at least one low cycle between grants.
REQ-022 An edge SHALL take priority over a simultaneous clear (ACK or W1C) on the same bit: the bit stays set.
REQ-023 An ACK write outside GRANT SHALL be ignored.
REQ-024 grant_id SHALL hold its value in HOLD and IDLE until the next grant.
REQ-025 MASK bits SHALL NOT gate the capture of PENDING; they gate only arbitration.

Reset
REQ-026 On reset_n=0, asynchronously: state=IDLE, irq=0, readdata=0, PENDING=0, MASK=0, grant_id=0, synchronizers=0, round-robin pointer=0.
REQ-027 A reset asserted mid-GRANT SHALL drop irq immediately, without waiting for a clk edge.
REQ-028 After reset_n deasserts, any source already high SHALL NOT produce an edge until it falls and rises again.

Configuration
REQ-029 Macro IRQ_ARBITER_RR_EN defined: the block SHALL use round-robin arbitration, searching from (last grant_id+1) mod N_SRC upward with wrap-around.
REQ-030 Macro IRQ_ARBITER_RR_EN undefined: the block SHALL use fixed priority, with the lowest index winning, and SHALL have no pointer register.

Verification
REQ-031 Scenario: MASK=0x01, pulse irq_src[0] -> PENDING=0x01 after 3 cycles, irq=1 one cycle later, VECTOR reads 0x80000000; ACK -> irq=0, PENDING=0x00.
REQ-032 Scenario: MASK=0xFF, raise irq_src[2] and irq_src[5] on the same cycle, then ACK each grant -> RR build grants 2 then 5; fixed build grants 2 then 5; repeat with pointer at 3 -> RR grants 5 first.
REQ-033 Scenario: during GRANT of source 1, write MASK=0x00 -> irq low next cycle, PENDING still 0x02; write MASK=0x02 -> regrant of source 1.
REQ-034 Scenario: re-edge on irq_src[0] coincident with the ACK cycle -> PENDING[0] remains 1, a new grant follows after the 1-cycle HOLD gap.
REQ-035 Scenario: assert reset_n=0 mid-GRANT -> irq=0 and readdata=0 immediately; with irq_src held high through the reset release -> no pending bit set.
REQ-036 Scenario: ACK write in IDLE, and a W1C write of 0x04 with PENDING=0x05 -> no state change in IDLE, and PENDING=0x01 respectively.
